// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and default sizes for the FIFO write-side arbiter
package fifo_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  localparam int ARB_NUM_REQ   = 4;
  localparam int ARB_BURST_MAX = 4;

endpackage

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - combinational round-robin picker
// Returns the first set request after rr_ptr, wrapping modulo N.
module fifo_rr_pick
  import fifo_pkg::*;
#(
  parameter int N  = ARB_NUM_REQ,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    // Scan from the farthest candidate down so the nearest one is kept last.
    for (int k = N; k >= 1; k--) begin
      j = (int'(rr_ptr) + k) % N;
      if (req[j[IW-1:0]]) begin
        valid = 1'b1;
        idx   = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the asfifo write port
// One producer owns the port per grant; full stalls the burst without releasing it.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = ARB_BURST_MAX,
  parameter int OW         = $clog2(NUM_REQ),
  parameter int CW         = $clog2(BURST_MAX + 1)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          we,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          busy,
  output logic [OW-1:0]                 owner
);

  arb_state_t          r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [OW-1:0]       r_owner;
  logic [OW-1:0]       r_rr_ptr;
  logic [CW-1:0]       r_beat_cnt;

  logic                w_pick_valid;
  logic [OW-1:0]       w_pick_idx;
  logic                w_busy;
  logic                w_owner_req;
  logic                w_we;
  logic                w_last_beat;
  logic                w_release;
  logic [DATA_WIDTH-1:0] w_data;

  fifo_rr_pick #(.N(NUM_REQ), .IW(OW)) u_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .valid  (w_pick_valid),
    .idx    (w_pick_idx)
  );

  assign w_busy      = (r_state == ARB_BURST);
  assign w_owner_req = req[r_owner];
  assign w_we        = w_busy & w_owner_req & ~full;
  assign w_last_beat = last[r_owner] | (r_beat_cnt == CW'(BURST_MAX - 1));
  // Abandon releases even under backpressure; last only counts on an accepted beat.
  assign w_release   = w_busy & ((w_we & w_last_beat) | ~w_owner_req);

  always_comb begin
    w_data = '0;
    if (w_busy) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_owner == i[OW-1:0]) w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      r_state    <= ARB_IDLE;
      r_gnt      <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= OW'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else if (r_state == ARB_IDLE) begin
      if (w_pick_valid) begin
        r_state    <= ARB_BURST;
        r_gnt      <= NUM_REQ'(1) << w_pick_idx;
        r_owner    <= w_pick_idx;
        r_rr_ptr   <= w_pick_idx;
        r_beat_cnt <= '0;
      end
    end else if (w_release) begin
      r_state    <= ARB_IDLE;
      r_gnt      <= '0;
      r_beat_cnt <= '0;
    end else if (w_we) begin
      r_beat_cnt <= r_beat_cnt + CW'(1);
    end
  end

  assign we      = w_we;
  assign ack     = w_we ? r_gnt : '0;
  assign gnt     = r_gnt;
  assign data_in = w_data;
  assign busy    = w_busy;
  assign owner   = r_owner;

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      assert ($onehot0(r_gnt));
      assert (!(w_we && full));
      assert ((ack & ~r_gnt) == '0);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        wr_rst;
  logic [3:0]  req, last, ack, gnt;
  logic [31:0] req_data;
  logic        full, we, busy;
  logic [7:0]  data_in;
  logic [1:0]  owner;

  logic [3:0]  req1, ack1, gnt1;
  logic [31:0] req_data1;
  logic        full1, we1, busy1;
  logic [7:0]  data_in1;
  logic [1:0]  owner1;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int viol = 0;
  int fcount = 0;
  int w0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(4)) u_dut (
    .wr_clk(clk), .wr_rst(wr_rst), .req(req), .last(last), .req_data(req_data),
    .full(full), .ack(ack), .gnt(gnt), .we(we), .data_in(data_in),
    .busy(busy), .owner(owner)
  );

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(1)) u_dut1 (
    .wr_clk(clk), .wr_rst(wr_rst), .req(req1), .last(4'b0000), .req_data(req_data1),
    .full(full1), .ack(ack1), .gnt(gnt1), .we(we1), .data_in(data_in1),
    .busy(busy1), .owner(owner1)
  );

  assign full1 = (fcount >= 16);

  always @(posedge clk) begin
    if (we) wr_count <= wr_count + 1;
    if (we && full) viol <= viol + 1;
    if (we1) fcount <= fcount + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    wr_rst = 1'b0; req = '0; last = '0; req_data = '0; full = 1'b0;
    req1 = '0; req_data1 = {8'h00, 8'h00, 8'hB1, 8'hB0};
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_data", 32'(data_in), 32'h0);

    // Single producer, four-beat burst ending with last
    wr_rst = 1'b1;
    req = 4'b0001; req_data = 32'h000000A0;
    #1;
    chk("t1_latency_gnt", 32'(gnt), 32'h0);
    chk("t1_latency_we", 32'(we), 32'h0);
    tick();
    chk("t1_gnt", 32'(gnt), 32'h1);
    for (int b = 0; b < 4; b++) begin
      req_data = 32'(8'hA0 + b);
      last = (b == 3) ? 4'b0001 : 4'b0000;
      #1;
      chk("t1_we", 32'(we), 32'h1);
      chk("t1_data", 32'(data_in), 32'(8'hA0 + b));
      chk("t1_ack", 32'(ack), 32'h1);
      tick();
    end
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_idle_gnt", 32'(gnt), 32'h0);
    req = '0; last = '0;

    // All four requesting: rr order 0,1,2,3,0,1,2,3 with bubbles
    wr_rst = 1'b0; tick(); wr_rst = 1'b1;
    req = 4'b1111; req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    for (int g = 0; g < 8; g++) begin
      tick();
      chk("t2_gnt", 32'(gnt), 32'(4'b0001 << (g % 4)));
      chk("t2_owner", 32'(owner), 32'(g % 4));
      for (int b = 0; b < 4; b++) begin
        chk("t2_we", 32'(we), 32'h1);
        chk("t2_data", 32'(data_in), 32'(8'hD0 + (g % 4)));
        tick();
      end
      chk("t2_bubble_busy", 32'(busy), 32'h0);
      chk("t2_bubble_we", 32'(we), 32'h0);
    end
    req = '0;

    // Requester 2 stalled by full for five cycles after beat 2
    w0 = wr_count;
    req = 4'b0100;
    tick();
    chk("t3_gnt", 32'(gnt), 32'h4);
    for (int b = 0; b < 2; b++) begin
      chk("t3_we_pre", 32'(we), 32'h1);
      tick();
    end
    full = 1'b1; last = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_full_we", 32'(we), 32'h0);
      chk("t3_full_ack", 32'(ack), 32'h0);
      chk("t3_full_gnt", 32'(gnt), 32'h4);
      tick();
    end
    full = 1'b0; last = '0;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("t3_we_post", 32'(we), 32'h1);
      tick();
    end
    chk("t3_done_gnt", 32'(gnt), 32'h0);
    chk("t3_writes", 32'(wr_count - w0), 32'd4);
    chk("t3_no_write_full", 32'(viol), 32'd0);
    req = '0;

    // Requester 1 abandons after one beat; next search starts after 1
    req = 4'b0010;
    tick();
    chk("t4_gnt", 32'(gnt), 32'h2);
    chk("t4_we", 32'(we), 32'h1);
    tick();
    req = 4'b0000;
    #1;
    chk("t4_drop_we", 32'(we), 32'h0);
    chk("t4_drop_gnt_hold", 32'(gnt), 32'h2);
    tick();
    chk("t4_released", 32'(gnt), 32'h0);
    req = 4'b1010;
    tick();
    chk("t4_next_gnt", 32'(gnt), 32'h8);
    chk("t4_next_owner", 32'(owner), 32'd3);

    // Async reset during beat 2 of requester 3
    chk("t5_beat1_we", 32'(we), 32'h1);
    tick();
    chk("t5_beat2_data", 32'(data_in), 32'hD3);
    #1;
    wr_rst = 1'b0;
    #1;
    chk("t5_rst_gnt", 32'(gnt), 32'h0);
    chk("t5_rst_we", 32'(we), 32'h0);
    tick();
    chk("t5_rst_hold_we", 32'(we), 32'h0);
    req = 4'b1001; wr_rst = 1'b1;
    #1;
    chk("t5_after_rst_gnt", 32'(gnt), 32'h0);
    tick();
    chk("t5_first_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    chk("t5_abandon", 32'(busy), 32'h0);

    // BURST_MAX=1: alternating single-beat grants until the FIFO fills
    req1 = 4'b0011;
    for (int g = 0; g < 16; g++) begin
      tick();
      chk("t6_gnt", 32'(gnt1), 32'((g % 2 == 1) ? 4'b0010 : 4'b0001));
      chk("t6_we", 32'(we1), 32'h1);
      chk("t6_data", 32'(data_in1), 32'((g % 2 == 1) ? 8'hB1 : 8'hB0));
      tick();
      chk("t6_bubble", 32'(busy1), 32'h0);
    end
    tick();
    chk("t6_full_flag", 32'(full1), 32'h1);
    chk("t6_full_gnt", 32'(gnt1), 32'h1);
    chk("t6_full_we", 32'(we1), 32'h0);
    tick();
    chk("t6_full_hold_gnt", 32'(gnt1), 32'h1);
    chk("t6_full_hold_we", 32'(we1), 32'h0);
    req1 = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin burst arbiter that shares the asfifo write port among NUM_REQ producers in the write-clock domain. It grants one producer at a time for a bounded burst and muxes that producer's data onto the FIFO's we/data_in. It honours the FIFO full flag as backpressure and reports the current owner for debug and coverage.

Parameters:
NUM_REQ, 4, number of producers sharing the FIFO write port
DATA_WIDTH, 8, FIFO data width; must match the asfifo data_in width
BURST_MAX, 4, maximum accepted beats per grant (>=1)

Ports:
wr_clk  input  1  write-domain clock; the block's only clock
wr_rst  input  1  reset, asynchronous, active-low
req  input  NUM_REQ  per-producer write request (level)
last  input  NUM_REQ  per-producer end-of-burst marker, qualified by req
req_data  input  NUM_REQ*DATA_WIDTH  producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
full  input  1  asfifo full flag
ack  output  NUM_REQ  beat accepted this cycle (one-hot or zero)
gnt  output  NUM_REQ  registered one-hot grant
we  output  1  FIFO write enable
data_in  output  DATA_WIDTH  FIFO write data
busy  output  1  high in BURST state
owner  output  $clog2(NUM_REQ)  index of current grant holder

Behaviour:
- Reset (wr_rst low, async): state=IDLE, gnt=0, owner=0, beat_cnt=0, rr_ptr=NUM_REQ-1 (so requester 0 wins the first arbitration), busy=0. Combinational we/ack/data_in are then 0.
- FSM states: IDLE and BURST.
- IDLE, req!=0 at edge t: pick the first i in order rr_ptr+1 .. rr_ptr+NUM_REQ (mod NUM_REQ) with req[i]=1.
  - On that edge: owner=i, gnt=1<<i, rr_ptr=i, beat_cnt=0, state=BURST.
  - The grant is visible in cycle t+1, giving one cycle of arbitration latency.
- IDLE, req==0: stay in IDLE. we=0, ack=0, data_in=0.
- BURST combinational outputs:
  - we = req[owner] & ~full
  - ack = we ? gnt : 0
  - data_in = req_data[owner] (driven whenever busy)
- BURST sequential behaviour:
  - Each accepted beat (we=1) increments beat_cnt; the counter width is $clog2(BURST_MAX+1).
  - While full=1, no beat is accepted. The grant and beat_cnt hold. There is no timeout.
- Release (at the edge: gnt=0, state=IDLE) when any of the following holds:
  - we & last[owner]
  - we & (beat_cnt==BURST_MAX-1)
  - ~req[owner] (abandon; holds even when full=1)
- Release always passes through IDLE, so there is one idle bubble cycle between grants. The next arbitration starts from rr_ptr=old owner, which guarantees fairness.
- A lone continuous requester receives BURST_MAX beats, one bubble, then the grant again.
- BURST_MAX=1: exactly one beat per grant.
- last asserted with full=1: no release. The burst ends on the later accepted beat that still carries last.
- req changes of non-owners during BURST are ignored until the next IDLE.
- Reset mid-burst: the grant drops immediately (async). No we is emitted while wr_rst is low.
- Invariants (asserted in RTL):
  - gnt is $onehot0
  - we implies ~full
  - ack implies gnt

Decomposition:
- fifo_pkg gets:
  - typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t
  - constants ARB_NUM_REQ=4 and ARB_BURST_MAX=4 (the test-environment defaults)
- One sub-module: fifo_rr_pick, a combinational round-robin picker.
  - Inputs: req, rr_ptr.
  - Outputs: valid, idx.
  - It is reused later for the read-side scheduler.
- The remaining FSM, counter and mux live in fifo_wr_arbiter.

Test Plan:
- Reset then req=4'b0001, req_data[0]=8'hA0..A3 incrementing, last on the 4th beat, full=0 -> gnt=0001 one cycle after req; we=1 for 4 consecutive cycles with data_in A0,A1,A2,A3; ack[0] each beat; then IDLE.
- req=4'b1111 held, no last, full=0 -> grants in order 0,1,2,3,0; each grant 4 beats (BURST_MAX) followed by a 1-cycle bubble; rr order verified over 8 grants.
- Requester 2 granted, full=1 for 5 cycles mid-burst after beat 2 -> we=0, ack=0, gnt stays 0100, beat_cnt holds; after full=0 the remaining 2 beats complete; total FIFO writes = 4, with no write while full.
- Requester 1 granted, drops req after 1 beat without last -> gnt clears next edge; next arbitration starts after index 1 (requester 3 wins when req=4'b1010).
- wr_rst pulled low mid-burst (beat 2 of requester 3) -> gnt=0, we=0 immediately (async); after release with req=4'b1001, requester 0 is granted first.
- BURST_MAX=1 build, req=4'b0011 -> alternating single-beat grants 0,1,0,1, each separated by one bubble; 16 writes fill the FIFO and full stops we.
